// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; one outstanding transaction.
// Latency: request to gnt is 0 cycles when mem_gnt is already high; response is routed combinationally.
// Backpressure: the loser and the locked owner hold their request until gnt. No new request in the rvalid cycle.
//
// Ports: clk/rst_n (async active-low); fetch side if_req/if_addr -> if_gnt/if_rvalid/if_rdata;
//        data side d_req/d_we/d_addr/d_wdata/d_be -> d_gnt/d_rvalid/d_rdata;
//        memory side mem_req/mem_we/mem_addr/mem_wdata/mem_be, mem_gnt/mem_rvalid/mem_rdata; err_spurious (sticky).
// Build option: define ARB_RR_EN for round-robin tie-breaking; otherwise fixed priority, data over fetch.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err_spurious
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  state_t state;
  logic   owner_d;     // 1 = data requester owns the port, 0 = fetch
  logic   sel_d;       // requester currently driving mem_* is data
  logic   active;      // a request is being presented to memory this cycle
  logic   tie_pick_d;  // winner on a simultaneous request in IDLE
  logic   rsp_hit;

`ifdef ARB_RR_EN
  logic last_winner_d; // 1 = data was granted last, 0 = fetch

  // On a tie, whoever was not granted last goes first.
  assign tie_pick_d = ~last_winner_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner_d <= 1'b0;
    end else if (if_gnt || d_gnt) begin
      last_winner_d <= d_gnt;
    end
  end
`else
  assign tie_pick_d = 1'b1;
`endif

  // Source selection: free choice in IDLE, locked to the owner otherwise.
  always_comb begin
    sel_d  = owner_d;
    active = 1'b0;
    case (state)
      ST_IDLE: begin
        active = d_req | if_req;
        sel_d  = d_req & (~if_req | tie_pick_d);
      end
      ST_REQ: begin
        // Owner dropping req before gnt withdraws the request entirely.
        active = owner_d ? d_req : if_req;
      end
      default: begin
        active = 1'b0;
      end
    endcase
  end

  assign mem_req   = active;
  assign mem_addr  = active ? (sel_d ? d_addr : if_addr) : '0;
  assign mem_we    = active & sel_d & d_we;
  assign mem_wdata = (active & sel_d) ? d_wdata : '0;
  assign mem_be    = (active & sel_d) ? d_be : '0;

  assign d_gnt  = active &  sel_d & mem_gnt;
  assign if_gnt = active & ~sel_d & mem_gnt;

  // Response goes straight through to the owner; anything outside RSP is dropped.
  assign rsp_hit   = (state == ST_RSP) & mem_rvalid;
  assign d_rvalid  = rsp_hit &  owner_d;
  assign if_rvalid = rsp_hit & ~owner_d;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      owner_d      <= 1'b1;
      err_spurious <= 1'b0;
    end else begin
      if (mem_rvalid && (state != ST_RSP)) begin
        err_spurious <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (active) begin
            owner_d <= sel_d;
            state   <= mem_gnt ? ST_RSP : ST_REQ;
          end
        end
        ST_REQ: begin
          if (!active) begin
            state <= ST_IDLE;
          end else if (mem_gnt) begin
            state <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (mem_rvalid) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err_spurious;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err_spurious(err_spurious)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_be = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    tick(); tick();
    settle();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_gnts", {30'd0, if_gnt, d_gnt}, 32'd0);
    chk("rst_rvalids", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_err", {31'd0, err_spurious}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single fetch, immediate gnt, response next cycle.
    if_req = 1; if_addr = 32'h100; mem_gnt = 1;
    settle();
    chk("f1_if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("f1_d_gnt", {31'd0, d_gnt}, 32'd0);
    chk("f1_mem_addr", mem_addr, 32'h100);
    chk("f1_mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00500093;
    settle();
    chk("f1_rsp_mem_req", {31'd0, mem_req}, 32'd0);
    chk("f1_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("f1_if_rdata", if_rdata, 32'h00500093);
    chk("f1_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    tick();
    mem_rvalid = 0;

    // Tie in IDLE, held across two transactions.
    d_req = 1; d_addr = 32'h200; if_req = 1; if_addr = 32'h300; mem_gnt = 1;
    settle();
    chk("tie1_d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("tie1_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("tie1_mem_addr", mem_addr, 32'h200);
    tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h11112222;
    settle();
    chk("tie1_no_issue_in_rsp", {31'd0, mem_req}, 32'd0);
    chk("tie1_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("tie1_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("tie1_d_rdata", d_rdata, 32'h11112222);
    tick();
    mem_rvalid = 0; mem_gnt = 1;
    settle();
`ifdef ARB_RR_EN
    chk("tie2_if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("tie2_d_gnt", {31'd0, d_gnt}, 32'd0);
    chk("tie2_mem_addr", mem_addr, 32'h300);
`else
    chk("tie2_d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("tie2_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("tie2_mem_addr", mem_addr, 32'h200);
`endif
    tick();
    d_req = 0; if_req = 0; mem_gnt = 0; mem_rvalid = 1;
    tick();
    mem_rvalid = 0;

    // Lock: fetch waits 3 cycles for gnt while data requests meanwhile.
    if_req = 1; if_addr = 32'h400;
    settle();
    chk("lock_c0_mem_req", {31'd0, mem_req}, 32'd1);
    chk("lock_c0_if_gnt", {31'd0, if_gnt}, 32'd0);
    tick();
    d_req = 1; d_addr = 32'h500;
    settle();
    chk("lock_c1_mem_addr", mem_addr, 32'h400);
    chk("lock_c1_d_gnt", {31'd0, d_gnt}, 32'd0);
    tick();
    settle();
    chk("lock_c2_mem_addr", mem_addr, 32'h400);
    tick();
    mem_gnt = 1;
    settle();
    chk("lock_c3_if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("lock_c3_d_gnt", {31'd0, d_gnt}, 32'd0);
    chk("lock_c3_mem_addr", mem_addr, 32'h400);
    tick();
    if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE0001;
    settle();
    chk("lock_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    tick();
    mem_rvalid = 0; mem_gnt = 1;
    settle();
    chk("lock_d_served_gnt", {31'd0, d_gnt}, 32'd1);
    chk("lock_d_served_addr", mem_addr, 32'h500);
    tick();
    d_req = 0; mem_gnt = 0; mem_rvalid = 1;
    tick();
    mem_rvalid = 0;

    // Store.
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011; mem_gnt = 1;
    settle();
    chk("st_d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("st_mem_we", {31'd0, mem_we}, 32'd1);
    chk("st_mem_addr", mem_addr, 32'h2000);
    chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_mem_be", {28'd0, mem_be}, 32'h3);
    tick();
    d_req = 0; d_we = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0;
    settle();
    chk("st_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    tick();
    mem_rvalid = 0;
    settle();
    chk("st_idle_mem_req", {31'd0, mem_req}, 32'd0);
    chk("st_idle_mem_we", {31'd0, mem_we}, 32'd0);
    chk("st_idle_wdata", mem_wdata, 32'd0);
    chk("st_idle_err", {31'd0, err_spurious}, 32'd0);

    // Owner withdraws in REQ: request drops, arbiter returns to IDLE.
    d_req = 1; d_addr = 32'h600;
    tick();
    d_req = 0;
    settle();
    chk("drop_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    if_req = 1; if_addr = 32'h700; mem_gnt = 1;
    settle();
    chk("drop_then_if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("drop_then_addr", mem_addr, 32'h700);
    tick();

    // Reset while in RSP, then a late response.
    if_req = 0; mem_gnt = 0;
    rst_n = 0;
    settle();
    rst_n = 1;
    mem_rvalid = 1; mem_rdata = 32'h12345678;
    settle();
    chk("late_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("late_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    tick();
    mem_rvalid = 0;
    settle();
    chk("late_err_set", {31'd0, err_spurious}, 32'd1);
    tick(); tick();
    chk("late_err_sticky", {31'd0, err_spurious}, 32'd1);
    rst_n = 0;
    settle();
    chk("err_cleared_by_reset", {31'd0, err_spurious}, 32'd0);
    rst_n = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
